// File: rtl/bc6502_pkg.sv
// Shared bc6502 definitions: sequencer states, flag-select codes and
// relative-branch opcodes.
package bc6502_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDLO = 2'b01,
        FIXHI = 2'b10,
        DONE  = 2'b11
    } branch_state_e;

    // cond[2:1] flag selectors
    localparam logic [1:0] FLG_N = 2'b00;
    localparam logic [1:0] FLG_V = 2'b01;
    localparam logic [1:0] FLG_C = 2'b10;
    localparam logic [1:0] FLG_Z = 2'b11;

    // Branch encodings: {flag select, required flag value}
    localparam logic [2:0] BPL = 3'b000;
    localparam logic [2:0] BMI = 3'b001;
    localparam logic [2:0] BVC = 3'b010;
    localparam logic [2:0] BVS = 3'b011;
    localparam logic [2:0] BCC = 3'b100;
    localparam logic [2:0] BCS = 3'b101;
    localparam logic [2:0] BNE = 3'b110;
    localparam logic [2:0] BEQ = 3'b111;

endpackage

// File: rtl/bc_branch_seq_if.sv
// Request/result bundle between the flag/PC path and the branch sequencer.
interface bc_branch_seq_if #(parameter int AW = 16);
    logic          start_i;
    logic [2:0]    cond_i;
    logic          n_i;
    logic          v_i;
    logic          c_i;
    logic          z_i;
    logic [AW-1:0] pc_i;
    logic [7:0]    off_i;
    logic          ready_o;
    logic          done_o;
    logic          taken_o;
    logic [AW-1:0] pc_o;
    logic [2:0]    cycles_o;

    modport master (
        output start_i, cond_i, n_i, v_i, c_i, z_i, pc_i, off_i,
        input  ready_o, done_o, taken_o, pc_o, cycles_o
    );

    modport slave (
        input  start_i, cond_i, n_i, v_i, c_i, z_i, pc_i, off_i,
        output ready_o, done_o, taken_o, pc_o, cycles_o
    );
endinterface

// File: rtl/bc_branch_cond.sv
// Combinational branch-condition evaluator: taken when the flag chosen by
// cond_i[2:1] equals cond_i[0].
module bc_branch_cond
    import bc6502_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic       n_i,
    input  logic       v_i,
    input  logic       c_i,
    input  logic       z_i,
    output logic       taken_o
);

    logic flag_s;

    // Select the flag named by the condition code
    always_comb begin
        flag_s = 1'b0;
        case (cond_i[2:1])
            FLG_N:   flag_s = n_i;
            FLG_V:   flag_s = v_i;
            FLG_C:   flag_s = c_i;
            FLG_Z:   flag_s = z_i;
            default: flag_s = 1'b0;
        endcase
    end

    assign taken_o = (flag_s == cond_i[0]);

endmodule

// File: rtl/bc_branch_seq.sv
// 6502 relative-branch sequencer: resolves taken/not-taken and the target PC
// with 2/3/4-cycle timing. Page-cross penalty state enabled by BC_BRANCH_PAGE_PENALTY_EN.
module bc_branch_seq
    import bc6502_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic               clk,
    input  logic               rst,
    bc_branch_seq_if.slave     bus
);

    branch_state_e state_r, state_nxt_s;

    logic [AW-1:0] pc_work_r, pc_work_nxt_s;
    logic [7:0]    off_r, off_nxt_s;
    logic [AW-1:0] pc_res_r, pc_res_nxt_s;
    logic          taken_r, taken_nxt_s;
    logic [2:0]    cycles_r, cycles_nxt_s;
    logic          ready_r;
    logic          done_r;
    logic          cond_taken_s;

    bc_branch_cond u_cond (
        .cond_i  (bus.cond_i),
        .n_i     (bus.n_i),
        .v_i     (bus.v_i),
        .c_i     (bus.c_i),
        .z_i     (bus.z_i),
        .taken_o (cond_taken_s)
    );

`ifdef BC_BRANCH_PAGE_PENALTY_EN
    localparam int HW = AW - 8;
    localparam logic [HW-1:0] HI_ONE = {{(HW-1){1'b0}}, 1'b1};

    logic [8:0]    sum9_s;
    logic          crossed_s;
    logic [HW-1:0] hi_adj_s;

    // Carry out of the low byte disagrees with the offset sign exactly on a page cross
    assign sum9_s    = {1'b0, pc_work_r[7:0]} + {1'b0, off_r};
    assign crossed_s = sum9_s[8] ^ off_r[7];
    assign hi_adj_s  = off_r[7] ? (pc_work_r[AW-1:8] - HI_ONE)
                                : (pc_work_r[AW-1:8] + HI_ONE);
`endif

    // Next-state and next-result logic
    always_comb begin
        state_nxt_s   = state_r;
        pc_work_nxt_s = pc_work_r;
        off_nxt_s     = off_r;
        pc_res_nxt_s  = pc_res_r;
        taken_nxt_s   = taken_r;
        cycles_nxt_s  = cycles_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    pc_work_nxt_s = bus.pc_i;
                    off_nxt_s     = bus.off_i;
                    if (cond_taken_s) begin
                        state_nxt_s = ADDLO;
                    end else begin
                        state_nxt_s  = DONE;
                        pc_res_nxt_s = bus.pc_i;
                        taken_nxt_s  = 1'b0;
                        cycles_nxt_s = 3'd2;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDLO: begin
`ifdef BC_BRANCH_PAGE_PENALTY_EN
                if (crossed_s) begin
                    state_nxt_s   = FIXHI;
                    pc_work_nxt_s = {pc_work_r[AW-1:8], sum9_s[7:0]};
                end else begin
                    state_nxt_s  = DONE;
                    pc_res_nxt_s = {pc_work_r[AW-1:8], sum9_s[7:0]};
                    taken_nxt_s  = 1'b1;
                    cycles_nxt_s = 3'd3;
                end
`else
                state_nxt_s  = DONE;
                pc_res_nxt_s = pc_work_r + {{(AW-8){off_r[7]}}, off_r};
                taken_nxt_s  = 1'b1;
                cycles_nxt_s = 3'd3;
`endif
            end
`ifdef BC_BRANCH_PAGE_PENALTY_EN
            FIXHI: begin
                state_nxt_s  = DONE;
                pc_res_nxt_s = {hi_adj_s, pc_work_r[7:0]};
                taken_nxt_s  = 1'b1;
                cycles_nxt_s = 3'd4;
            end
`endif
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pc_work_r <= {AW{1'b0}};
            off_r     <= 8'h00;
            pc_res_r  <= {AW{1'b0}};
            taken_r   <= 1'b0;
            cycles_r  <= 3'd0;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_work_r <= pc_work_nxt_s;
            off_r     <= off_nxt_s;
            pc_res_r  <= pc_res_nxt_s;
            taken_r   <= taken_nxt_s;
            cycles_r  <= cycles_nxt_s;
            ready_r   <= (state_nxt_s == IDLE);
            done_r    <= (state_nxt_s == DONE);
        end
    end

    assign bus.ready_o  = ready_r;
    assign bus.done_o   = done_r;
    assign bus.taken_o  = taken_r;
    assign bus.pc_o     = pc_res_r;
    assign bus.cycles_o = cycles_r;

endmodule
